// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

    typedef logic [31:0] word_t;

    localparam word_t PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC selection: sequential step or word-aligned branch target.
module next_pc_mux
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        take,
    input  logic [31:0] target,
    output logic [31:0] next_pc
);

    // Sequential step wraps naturally modulo 2^32.
    assign next_pc = take ? {target[31:2], 2'b00} : pc + PC_STEP;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: request, hold until consumed, advance PC.
// Optional fetch timeout enabled by defining FETCH_CTRL_TIMEOUT_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] pcbranch,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [15:0] fetch_count,
    output logic        err
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t state;
    word_t  pc;
    word_t  instr_q;
    word_t  pc_q;
    word_t  next_pc;
    logic   consume;

    assign consume = (state == HOLD) && !stall;

    next_pc_mux u_next_pc (
        .pc      (pc),
        .take    (branch & zero),
        .target  (pcbranch),
        .next_pc (next_pc)
    );

`ifdef FETCH_CTRL_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_cnt;
    logic              err_q;
    logic              timed_out;

    // Counter idles at zero outside REQ, so every entry to REQ starts fresh.
    always_ff @(posedge clk) begin
        if (reset || state != REQ) begin
            wait_cnt <= '0;
        end else if (!imem_ready) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    assign timed_out = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) && !imem_ready;
    assign err       = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr_q     <= '0;
            pc_q        <= '0;
            fetch_count <= '0;
`ifdef FETCH_CTRL_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        pc_q    <= pc;
                        state   <= HOLD;
                    end
`ifdef FETCH_CTRL_TIMEOUT_EN
                    else if (timed_out) begin
                        state <= ERR;
                        err_q <= 1'b1;
                    end
`endif
                end
                HOLD: begin
                    if (consume) begin
                        pc          <= next_pc;
                        fetch_count <= fetch_count + 16'd1;
                        state       <= run ? REQ : IDLE;
                    end
                end
                default: begin
                    state <= ERR;
                end
            endcase
        end
    end

    // Outputs decode the registered state; data buses read zero when not valid.
    assign imem_req    = (state == REQ);
    assign instr_valid = (state == HOLD);
    assign imem_addr   = imem_req ? pc : '0;
    assign instr       = instr_valid ? instr_q : '0;
    assign pc_out      = instr_valid ? pc_q : '0;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;
    localparam int          TMO     = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] pcbranch = '0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;

    logic        imem_req, instr_valid, err;
    logic [31:0] imem_addr, instr, pc_out;
    logic [15:0] fetch_count;

    logic        imem_req2, instr_valid2, err2;
    logic [31:0] imem_addr2, instr2, pc_out2;
    logic [15:0] fetch_count2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: transaction-level view of the controller.
    bit          m_req, m_hold, m_err;
    logic [31:0] m_pc, m_instr, m_pcout;
    logic [15:0] m_cnt;
    int          m_wait;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .run(run), .stall(stall), .branch(branch),
        .zero(zero), .pcbranch(pcbranch), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .pc_out(pc_out), .fetch_count(fetch_count), .err(err)
    );

    fetch_ctrl #(.RESET_PC(WRAP_PC), .TIMEOUT_CYCLES(TMO)) dut_wrap (
        .clk(clk), .reset(reset), .run(run), .stall(stall), .branch(branch),
        .zero(zero), .pcbranch(pcbranch), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(instr_valid2),
        .instr(instr2), .pc_out(pc_out2), .fetch_count(fetch_count2), .err(err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_req = 0; m_hold = 0; m_err = 0;
            m_pc = RST_PC; m_instr = '0; m_pcout = '0; m_cnt = '0; m_wait = 0;
        end else if (m_err) begin
            m_err = 1;
        end else if (m_hold) begin
            if (!stall) begin
                m_pc   = (branch && zero) ? (pcbranch & 32'hFFFF_FFFC) : m_pc + 32'd4;
                m_cnt  = m_cnt + 16'd1;
                m_hold = 0;
                m_req  = run;
                m_wait = 0;
            end
        end else if (m_req) begin
            if (imem_ready) begin
                m_instr = imem_rdata;
                m_pcout = m_pc;
                m_req   = 0;
                m_hold  = 1;
            end else begin
                m_wait++;
`ifdef FETCH_CTRL_TIMEOUT_EN
                if (m_wait == TMO) begin
                    m_req = 0;
                    m_err = 1;
                end
`endif
            end
        end else if (run) begin
            m_req  = 1;
            m_wait = 0;
        end
    endtask

    task automatic compare_all();
        check("imem_req",    {31'b0, imem_req},    {31'b0, m_req});
        check("imem_addr",   imem_addr,            m_req ? m_pc : 32'h0);
        check("instr_valid", {31'b0, instr_valid}, {31'b0, m_hold});
        check("instr",       instr,                m_hold ? m_instr : 32'h0);
        check("pc_out",      pc_out,               m_hold ? m_pcout : 32'h0);
        check("fetch_count", {16'b0, fetch_count}, {16'b0, m_cnt});
        check("err",         {31'b0, err},         {31'b0, m_err});
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        @(negedge clk);
        reset = 1; step(); step();
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_count", {16'b0, fetch_count}, 32'h0);
        check("rst_err",   {31'b0, err},         32'h0);
        reset = 0;

        // Basic fetch with two wait cycles.
        run = 1; imem_rdata = 32'h0000_0013; step();
        check("first_addr", imem_addr, 32'h0);
        check("wrap_first_addr", imem_addr2, WRAP_PC);
        step(); step();
        imem_ready = 1; step();
        imem_ready = 0;
        check("first_valid", {31'b0, instr_valid}, 32'h1);
        check("first_pcout", pc_out, 32'h0);
        check("first_instr", instr, 32'h0000_0013);

        // Stall holds the instruction.
        stall = 1;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1; branch = 1; zero = 1; pcbranch = 32'h100;
            step();
            check("stall_instr", instr, 32'h0000_0013);
            check("stall_req",   {31'b0, imem_req}, 32'h0);
            check("stall_count", {16'b0, fetch_count}, 32'h0);
        end
        stall = 0; branch = 0; zero = 0; imem_ready = 0; step();
        check("seq_addr", imem_addr, 32'h4);
        check("wrap_addr", imem_addr2, 32'h0);
        check("count_one", {16'b0, fetch_count}, 32'h1);

        // Taken branch, then not-taken branch.
        imem_ready = 1; step();
        imem_ready = 0; branch = 1; zero = 1; pcbranch = 32'h0000_0043; step();
        check("taken_addr", imem_addr, 32'h40);
        imem_ready = 1; branch = 0; zero = 0; step();
        imem_ready = 0; branch = 1; zero = 0; step();
        check("nottaken_addr", imem_addr, 32'h44);
        branch = 0;

        // Reset while a ready arrives in REQ.
        imem_ready = 1; reset = 1; step();
        check("rstreq_valid", {31'b0, instr_valid}, 32'h0);
        check("rstreq_req",   {31'b0, imem_req}, 32'h0);
        check("rstreq_count", {16'b0, fetch_count}, 32'h0);
        reset = 0; imem_ready = 0; run = 1; step();
        check("rstreq_pc", imem_addr, RST_PC);
        step();
        check("rstreq_still_valid0", {31'b0, instr_valid}, 32'h0);

`ifdef FETCH_CTRL_TIMEOUT_EN
        // Timeout: ready never arrives.
        reset = 1; step(); reset = 0; run = 1; imem_ready = 0; step();
        for (int i = 0; i < TMO - 1; i++) step();
        check("tmo_before_err", {31'b0, err}, 32'h0);
        check("tmo_before_req", {31'b0, imem_req}, 32'h1);
        step();
        check("tmo_err", {31'b0, err}, 32'h1);
        check("tmo_req", {31'b0, imem_req}, 32'h0);
        imem_ready = 1;
        for (int i = 0; i < 5; i++) step();
        check("tmo_sticky", {31'b0, err}, 32'h1);
        reset = 1; step(); reset = 0;
        check("tmo_cleared", {31'b0, err}, 32'h0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            run        = ($urandom_range(0, 7) != 0);
            stall      = $urandom_range(0, 1);
            branch     = $urandom_range(0, 1);
            zero       = $urandom_range(0, 1);
            pcbranch   = $urandom;
            imem_ready = ($urandom_range(0, 2) == 0);
            imem_rdata = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
